// File: rtl/nmr_seq_pkg.sv
// Shared types for the NMR sequencer blocks: scheduler FSM states, microsecond
// time type and the width helper for the microsecond tick counter.
package nmr_seq_pkg;

  typedef enum logic [2:0] {StIdle, StArm, StRun, StNext, StFin} shot_state_e;

  typedef logic [31:0] us_time_t;

  function automatic int unsigned us_tick_w(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/nmr_shot_scheduler_if.sv
// Register-bank side of the shot scheduler: train controls, latched parameters
// and the sequencer-facing outputs.
interface nmr_shot_scheduler_if
  import nmr_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] shots_in;
  us_time_t         reptime_in;
  us_time_t         abdly_in;
  us_time_t         dly_step_in;
  us_time_t         acq_dly_in;
  us_time_t         acq_len_in;
  logic             seq_rst;
  us_time_t         abdly_out;
  logic             shot_strobe;
  logic [CNT_W-1:0] shot_idx;
  logic             acq_gate;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, shots_in, reptime_in, abdly_in, dly_step_in, acq_dly_in, acq_len_in,
    input  seq_rst, abdly_out, shot_strobe, shot_idx, acq_gate, busy, done
  );

  modport slave (
    input  start, abort, shots_in, reptime_in, abdly_in, dly_step_in, acq_dly_in, acq_len_in,
    output seq_rst, abdly_out, shot_strobe, shot_idx, acq_gate, busy, done
  );
endinterface

// File: rtl/nmr_us_tick.sv
// Microsecond tick generator: US_DIVIDER down-counter with synchronous clear;
// tick is high for one cycle each time the counter reaches zero.
module nmr_us_tick
  import nmr_seq_pkg::*;
#(
  parameter int unsigned US_DIVIDER = 125
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  output logic tick
);
  localparam int unsigned W = us_tick_w(US_DIVIDER);
  localparam logic [W-1:0] Reload = W'(US_DIVIDER - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clear || (cnt_q == '0)) cnt_d = Reload;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cnt_q <= Reload;
    else       cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == '0) && !clear;
endmodule

// File: rtl/nmr_shot_scheduler.sv
// Shot-train repetition controller for the NMR pulse sequencer.
// Define SHOT_STEP_EN to advance abdly_out by dly_step (saturating) on every shot.
module nmr_shot_scheduler
  import nmr_seq_pkg::*;
#(
  parameter int unsigned US_DIVIDER = 125,
  parameter int unsigned CNT_W      = 16
) (
  input logic                 clk,
  input logic                 rstn,
  nmr_shot_scheduler_if.slave bus
);
  shot_state_e      state_q, state_d;
  logic [CNT_W-1:0] shots_q, idx_q, idx_d;
  us_time_t         rep_q, acq_dly_q, acq_len_q;
  us_time_t         abdly_q, abdly_d, t_q, t_d, next_abdly;
  logic             strobe_q, load, us_clear, us_tick, last_shot;
  logic [32:0]      gate_end;

  assign load      = (state_q == StIdle) && bus.start && !bus.abort;
  assign last_shot = (idx_q == shots_q - CNT_W'(1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shots_q   <= '0;
      rep_q     <= 32'd1;
      acq_dly_q <= '0;
      acq_len_q <= '0;
    end else if (load) begin
      shots_q   <= bus.shots_in;
      rep_q     <= (bus.reptime_in == '0) ? 32'd1 : bus.reptime_in;
      acq_dly_q <= bus.acq_dly_in;
      acq_len_q <= bus.acq_len_in;
    end
  end

`ifdef SHOT_STEP_EN
  us_time_t    step_q;
  logic [32:0] step_sum;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     step_q <= '0;
    else if (load) step_q <= bus.dly_step_in;
  end

  assign step_sum   = {1'b0, abdly_q} + {1'b0, step_q};
  assign next_abdly = step_sum[32] ? '1 : step_sum[31:0];
`else
  logic unused_step;
  assign unused_step = ^bus.dly_step_in;
  assign next_abdly  = abdly_q;
`endif

  nmr_us_tick #(
    .US_DIVIDER(US_DIVIDER)
  ) u_us_tick (
    .clk  (clk),
    .rstn (rstn),
    .clear(us_clear),
    .tick (us_tick)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    abdly_d  = abdly_q;
    t_d      = t_q;
    us_clear = 1'b0;
    if (bus.abort) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.shots_in == '0) begin
              state_d = StFin;
            end else begin
              state_d = StArm;
              abdly_d = bus.abdly_in;
              idx_d   = '0;
            end
          end
        end
        StArm: begin
          t_d      = '0;
          us_clear = 1'b1;
          state_d  = StRun;
        end
        StRun: begin
          if (us_tick) begin
            t_d = t_q + 32'd1;
            if (t_q == rep_q - 32'd1) begin
              state_d = StNext;
              // Advance ABdly on entry to NEXT so it is steady for both held cycles.
              if (!last_shot) abdly_d = next_abdly;
            end
          end
        end
        StNext: begin
          if (last_shot) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + CNT_W'(1);
            state_d = StArm;
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      abdly_q  <= '0;
      t_q      <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      abdly_q  <= abdly_d;
      t_q      <= t_d;
      strobe_q <= (state_q == StArm) && !bus.abort;
    end
  end

  assign gate_end        = {1'b0, acq_dly_q} + {1'b0, acq_len_q};
  assign bus.acq_gate    = (state_q == StRun) && (t_q >= acq_dly_q) && ({1'b0, t_q} < gate_end);
  assign bus.seq_rst     = (state_q != StRun);
  assign bus.busy        = (state_q == StArm) || (state_q == StRun) || (state_q == StNext);
  assign bus.done        = (state_q == StFin);
  assign bus.shot_strobe = strobe_q;
  assign bus.shot_idx    = idx_q;
  assign bus.abdly_out   = abdly_q;
endmodule

// File: tb/tb_nmr_shot_scheduler.sv
// Bench for nmr_shot_scheduler: table of directed trains, random trains against
// an arithmetic model, plus abort and asynchronous-reset sequences.
`timescale 1ns/1ps
module tb_nmr_shot_scheduler;
  import nmr_seq_pkg::*;

  localparam int unsigned DIV = 125;
  localparam int unsigned CW  = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #4 clk = ~clk;

  nmr_shot_scheduler_if #(.CNT_W(CW)) bus ();

  nmr_shot_scheduler #(
    .US_DIVIDER(DIV),
    .CNT_W     (CW)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct packed {
    logic [15:0]      shots;
    logic [31:0]      rep;
    logic [31:0]      abdly;
    logic [31:0]      step;
    logic [31:0]      acq_dly;
    logic [31:0]      acq_len;
    int               period;
    int               gate_cyc;
    int               gate_off;
    int               done_cyc;
    logic [3:0][31:0] exp_abdly;
  } vec_t;

  int vectors    = 0;
  int miscompares = 0;
  vec_t tbl[7];

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int shots, input logic [31:0] rep, abdly, step, dly, len,
                              input int period, gate_cyc, gate_off, done_cyc,
                              input logic [31:0] a0, a1, a2, a3);
    vec_t r;
    r.shots = 16'(shots); r.rep = rep; r.abdly = abdly; r.step = step;
    r.acq_dly = dly; r.acq_len = len;
    r.period = period; r.gate_cyc = gate_cyc; r.gate_off = gate_off; r.done_cyc = done_cyc;
    r.exp_abdly[0] = a0; r.exp_abdly[1] = a1; r.exp_abdly[2] = a2; r.exp_abdly[3] = a3;
    return r;
  endfunction

  // Expected train shape from the timing rules, in plain arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t   r = v;
    longint rep, dly, len, gs, ge, sum, step;
    rep = (v.rep == 0) ? 1 : v.rep;
    dly = v.acq_dly;
    len = v.acq_len;
    gs  = (dly < rep) ? dly : rep;
    ge  = dly + len;
    if (ge > rep) ge = rep;
    r.period   = int'(rep * DIV + 2);
    r.gate_cyc = (ge > gs) ? int'((ge - gs) * DIV) : 0;
    r.gate_off = int'(gs * DIV);
    r.done_cyc = int'(v.shots) * r.period + 1;
`ifdef SHOT_STEP_EN
    step = v.step;
`else
    step = 0;
`endif
    for (int k = 0; k < 4; k++) begin
      sum = v.abdly;
      sum = sum + k * step;
      if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
      r.exp_abdly[k] = sum[31:0];
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    bus.shots_in    = v.shots;
    bus.reptime_in  = v.rep;
    bus.abdly_in    = v.abdly;
    bus.dly_step_in = v.step;
    bus.acq_dly_in  = v.acq_dly;
    bus.acq_len_in  = v.acq_len;
  endtask

  task automatic run_train(input vec_t v, input vec_t e, input string tag);
    int strobes = 0, rst_low = 0, gate_cnt = 0, first_gate = -1, done_at = -1;
    int limit = e.done_cyc + 20;
    logic [31:0] ab1, ab2;
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    ab1 = bus.abdly_out;
    ab2 = ab1;
    for (int k = 1; k <= limit && done_at < 0; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.start       = 1'b0;
        bus.shots_in    = CW'($urandom);
        bus.reptime_in  = $urandom;
        bus.abdly_in    = $urandom;
        bus.dly_step_in = $urandom;
        bus.acq_dly_in  = $urandom;
        bus.acq_len_in  = $urandom;
      end
      bus.start = (k == 3);
      if (bus.shot_strobe) begin
        if (strobes < 4) begin
          check($sformatf("%s strobe%0d cycle", tag, strobes), k, 2 + strobes * e.period);
          check($sformatf("%s shot%0d idx", tag, strobes), bus.shot_idx, strobes);
          check($sformatf("%s shot%0d abdly arm", tag, strobes), ab1, e.exp_abdly[strobes]);
          if (strobes > 0)
            check($sformatf("%s shot%0d abdly next", tag, strobes), ab2, e.exp_abdly[strobes]);
        end
        strobes++;
      end
      if (!bus.seq_rst) rst_low++;
      if (bus.acq_gate) begin
        gate_cnt++;
        if (first_gate < 0) first_gate = k;
      end
      if (bus.done) done_at = k;
      ab2 = ab1;
      ab1 = bus.abdly_out;
    end
    bus.start = 1'b0;
    check({tag, " strobes"}, strobes, v.shots);
    check({tag, " seq_rst low"}, rst_low, int'(v.shots) * (e.period - 2));
    check({tag, " gate cycles"}, gate_cnt, int'(v.shots) * e.gate_cyc);
    if (e.gate_cyc > 0 && v.shots > 0) check({tag, " gate offset"}, first_gate - 2, e.gate_off);
    check({tag, " done cycle"}, done_at, e.done_cyc);
    @(negedge clk);
    check({tag, " busy after"}, bus.busy, 0);
    check({tag, " done 1 cycle"}, bus.done, 0);
    check({tag, " held after"}, bus.seq_rst, 1);
    if (v.shots > 0) check({tag, " last idx"}, bus.shot_idx, int'(v.shots) - 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n, cnt, low;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    tbl[0] = mk(3, 10, 7, 0, 0, 0, 1252, 0, 0, 3757, 7, 7, 7, 0);
    tbl[1] = mk(2, 10, 5, 0, 2, 3, 1252, 375, 250, 2505, 5, 5, 0, 0);
    tbl[2] = mk(1, 10, 0, 0, 8, 10, 1252, 250, 1000, 1253, 0, 0, 0, 0);
    tbl[3] = mk(0, 5, 9, 0, 0, 0, 627, 0, 0, 1, 0, 0, 0, 0);
    tbl[4] = mk(1, 0, 3, 0, 0, 1, 127, 125, 0, 128, 3, 0, 0, 0);
`ifdef SHOT_STEP_EN
    tbl[5] = mk(4, 1, 100, 50, 0, 0, 127, 0, 0, 509, 100, 150, 200, 250);
    tbl[6] = mk(3, 1, 32'hFFFF_FFF0, 16, 0, 0, 127, 0, 0, 382,
                32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
`else
    tbl[5] = mk(4, 1, 100, 50, 0, 0, 127, 0, 0, 509, 100, 100, 100, 100);
    tbl[6] = mk(3, 1, 32'hFFFF_FFF0, 16, 0, 0, 127, 0, 0, 382,
                32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0, 0);
`endif

    #13;
    check("reset seq_rst", bus.seq_rst, 1);
    check("reset abdly", bus.abdly_out, 0);
    check("reset strobe", bus.shot_strobe, 0);
    check("reset idx", bus.shot_idx, 0);
    check("reset gate", bus.acq_gate, 0);
    check("reset busy", bus.busy, 0);
    check("reset done", bus.done, 0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_train(tbl[i], tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 10; i++) begin
      v.shots   = 16'($urandom_range(0, 3));
      v.rep     = $urandom_range(0, 4);
      v.abdly   = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FF00 + $urandom_range(0, 255);
      v.step    = $urandom_range(0, 1) ? $urandom_range(0, 500) : $urandom;
      v.acq_dly = $urandom_range(0, 5);
      v.acq_len = $urandom_range(0, 6);
      run_train(v, model(v), $sformatf("rnd%0d", i));
    end

    // Abort in the middle of shot 1.
    v = mk(3, 2, 77, 0, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(v);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cnt = 0;
    n = 0;
    while (cnt < 2 && n < 3000) begin
      @(negedge clk);
      n++;
      if (bus.shot_strobe) cnt++;
    end
    check("abort reached shot1", cnt, 2);
    repeat (50) @(negedge clk);
    check("abort pre gate", bus.acq_gate, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort seq_rst", bus.seq_rst, 1);
    check("abort gate", bus.acq_gate, 0);
    check("abort busy", bus.busy, 0);
    check("abort done", bus.done, 0);
    check("abort idx hold", bus.shot_idx, 1);
    cnt = 0;
    low = 0;
    repeat (400) begin
      @(negedge clk);
      if (bus.done) cnt++;
      if (!bus.seq_rst) low++;
    end
    check("abort no done", cnt, 0);
    check("abort stays held", low, 0);

    // Start and abort together while idle.
    drive(mk(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    cnt = 0;
    repeat (10) begin
      if (bus.busy || bus.shot_strobe || bus.done || !bus.seq_rst) cnt++;
      @(negedge clk);
    end
    check("start+abort idle", cnt, 0);

    // Asynchronous reset during RUN.
    drive(mk(2, 3, 123, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (200) @(negedge clk);
    check("rst pre gate", bus.acq_gate, 1);
    check("rst pre abdly", bus.abdly_out, 123);
    #1 rstn = 1'b0;
    #1;
    check("async rst seq_rst", bus.seq_rst, 1);
    check("async rst abdly", bus.abdly_out, 0);
    check("async rst strobe", bus.shot_strobe, 0);
    check("async rst idx", bus.shot_idx, 0);
    check("async rst gate", bus.acq_gate, 0);
    check("async rst busy", bus.busy, 0);
    check("async rst done", bus.done, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
